misr_sig_engine: RTL
====================

// Module: misr_sig_engine
// PURPOSE
//   Parametrised multiple-input signature register (MISR) engine for systolic-array BIST.
//   - Compacts a programmed number of valid data words into an N-bit signature.
//   - Polynomial is set by a parameter; seed is loaded at run start.
//   - Start/busy/done handshake for the BIST controller.
//   - Optional on-chip golden-signature compare.
//   Sits between the array output mux and the BIST controller.
// PARAMETERS
//   NUM_BITS  54                   signature / data width (>=2)
//   TAP_MASK  54'h30000000030000   feedback taps; bit k set = sig[k] tapped (default = taps 54,53,18,17)
//   CNT_W     16                   width of word-count length and counter
// PORTS
//   i_clk       in   1         clock, rising edge
//   i_rst       in   1         reset, asynchronous, active-high
//   i_start     in   1         start pulse; accepted in IDLE or DONE only
//   i_seed      in   NUM_BITS  signature seed, sampled with i_start
//   i_len       in   CNT_W     number of words to compact, sampled with i_start
//   i_data_vld  in   1         i_data valid this cycle
//   i_data      in   NUM_BITS  data word to compact
//   i_golden    in   NUM_BITS  expected signature (MISR_GOLDEN_CMP_EN only)
//   o_busy      out  1         high in RUN
//   o_done      out  1         high in DONE; held until next accepted i_start
//   o_sig       out  NUM_BITS  current signature register
//   o_cnt       out  CNT_W     words compacted so far this run
//   o_pass      out  1         registered compare result (MISR_GOLDEN_CMP_EN only)
// BEHAVIOUR
//   - Reset: state=IDLE; sig, cnt, len, o_busy, o_done, o_pass all 0.
//   - Feedback: fb = ~(^(sig & TAP_MASK)) (XNOR form).
//     Update: sig <= {sig[NUM_BITS-2:0], fb} ^ i_data.
//     sig[NUM_BITS-1] is shifted out and discarded.
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE/DONE + i_start:
//     - sig<=i_seed; cnt<=0; len<=i_len; o_done<=0.
//     - Next state is RUN, or DONE if i_len==0 (sig=seed, o_done=1 next cycle).
//   - RUN, i_data_vld=1: one compaction step; cnt<=cnt+1.
//     - If cnt==len-1: go to DONE next cycle; o_busy drops and o_done rises in the same cycle.
//   - RUN, i_data_vld=0: sig and cnt hold; gaps of any length are allowed.
//   - Data outside RUN is ignored; sig holds in IDLE/DONE.
//   - i_start during RUN is ignored; no restart, no error.
//   - i_start in DONE is a legal restart; DONE->RUN directly.
//   - Latency: the final valid word is reflected in o_sig the cycle o_done=1.
//   - All-ones is the XNOR lock-up state; seeding all-ones with zero data keeps sig all-ones (legal, not flagged).
//   - Async reset mid-run: immediate return to reset values; the run is discarded.
//   - cnt never wraps: max run length is 2^CNT_W-1 words.
// CONFIGURATION
//   MISR_GOLDEN_CMP_EN
//   - Defined:
//     - i_golden and o_pass exist.
//     - On the cycle entering DONE: o_pass <= (next sig == i_golden), held through DONE.
//     - o_pass is cleared on i_start and on reset.
//   - Undefined: i_golden and o_pass are absent; no comparator logic.
// TESTING  (NUM_BITS=8, TAP_MASK=8'hB8, CNT_W=4)
//   1) Reset release -> state IDLE; o_sig=0, o_cnt=0, o_busy=0, o_done=0.
//   2) seed=00, len=2, data 00,00 back-to-back -> sig 01 then 03; o_done=1 after 2nd word, o_cnt=2.
//   3) seed=FF, len=1, data 00 -> o_sig=FF (lock-up). i_len=0 start -> DONE next cycle, o_sig=seed, o_cnt=0.
//   4) len=3 with vld pattern 1,0,0,1,0,1 -> sig equals 3-word gapless reference; i_start mid-run ignored.
//   5) Assert i_rst after 1 of 4 words -> all outputs 0 immediately; a new start runs cleanly.
//   6) MISR_GOLDEN_CMP_EN: scenario 2 with golden 03 -> o_pass=1; golden 02 -> o_pass=0.
//      Restart clears o_pass.

Source files
------------

// File: rtl/misr_sig_engine.sv
// Multiple-input signature register engine with start/busy/done handshake for BIST.
// Optional golden-signature compare is enabled by defining MISR_GOLDEN_CMP_EN.
module misr_sig_engine #(
  parameter int unsigned         NUM_BITS = 54,
  parameter logic [NUM_BITS-1:0] TAP_MASK = 54'h30000000030000,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NUM_BITS-1:0] i_seed,
  input  logic [CNT_W-1:0]    i_len,
  input  logic                i_data_vld,
  input  logic [NUM_BITS-1:0] i_data,
`ifdef MISR_GOLDEN_CMP_EN
  input  logic [NUM_BITS-1:0] i_golden,
  output logic                o_pass,
`endif
  output logic                o_busy,
  output logic                o_done,
  output logic [NUM_BITS-1:0] o_sig,
  output logic [CNT_W-1:0]    o_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  logic [NUM_BITS-1:0] sig;
  logic [NUM_BITS-1:0] sig_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    len;
  logic [CNT_W-1:0]    last_idx;
  logic                fb;

  // XNOR feedback: all-ones is the lock-up state rather than all-zeros.
  always_comb begin
    fb       = ~(^(sig & TAP_MASK));
    sig_next = {sig[NUM_BITS-2:0], fb} ^ i_data;
    last_idx = len - CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      sig    <= '0;
      cnt    <= '0;
      len    <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
`ifdef MISR_GOLDEN_CMP_EN
      o_pass <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            sig <= i_seed;
            cnt <= '0;
            len <= i_len;
            if (i_len == '0) begin
              // Zero-length run completes immediately with the seed as signature.
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
`ifdef MISR_GOLDEN_CMP_EN
              o_pass <= (i_seed == i_golden);
`endif
            end else begin
              state  <= RUN;
              o_busy <= 1'b1;
              o_done <= 1'b0;
`ifdef MISR_GOLDEN_CMP_EN
              o_pass <= 1'b0;
`endif
            end
          end
        end
        RUN: begin
          if (i_data_vld) begin
            sig <= sig_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == last_idx) begin
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
`ifdef MISR_GOLDEN_CMP_EN
              o_pass <= (sig_next == i_golden);
`endif
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_sig = sig;
  assign o_cnt = cnt;

endmodule
